// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types: FSM states, scancode constants, key indices and the scancode-to-key lookup.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [2:0] {
        KEY_P1_UP,
        KEY_P1_DOWN,
        KEY_P1_LEFT,
        KEY_P1_RIGHT,
        KEY_P2_UP,
        KEY_P2_DOWN,
        KEY_P2_LEFT,
        KEY_P2_RIGHT
    } key_idx_e;

    typedef struct packed {
        logic     hit;
        key_idx_e idx;
    } key_map_t;

    // Arrow codes only count with the E0 prefix; bare they are keypad keys.
    function automatic key_map_t lookup_key(input logic [7:0] code, input logic ext);
        key_map_t m;
        m.hit = 1'b1;
        m.idx = KEY_P1_UP;
        if (!ext) begin
            case (code)
                SC_W:    m.idx = KEY_P1_UP;
                SC_S:    m.idx = KEY_P1_DOWN;
                SC_A:    m.idx = KEY_P1_LEFT;
                SC_D:    m.idx = KEY_P1_RIGHT;
                default: m.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_UP:    m.idx = KEY_P2_UP;
                SC_DOWN:  m.idx = KEY_P2_DOWN;
                SC_LEFT:  m.idx = KEY_P2_LEFT;
                SC_RIGHT: m.idx = KEY_P2_RIGHT;
                default:  m.hit = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one asynchronous PS/2 line plus a falling-edge detector.
// Latency: level valid 2 cycles after the pin; fall pulses one cycle with the synchronized 1->0.
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = line_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Idle PS/2 lines are high, so reset to 1 keeps reset release from faking an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver decoding WASD and arrow keys into held-key levels; results appear one cycle after the stop edge.
// Optional PS2_WATCHDOG_EN: abandons a stalled frame after TIMEOUT_CYCLES cycles without a PS/2 clock edge.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p1_left,
    output logic       p1_right,
    output logic       p2_up,
    output logic       p2_down,
    output logic       p2_left,
    output logic       p2_right,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic clk_fall, clk_level_unused;
    logic data_lvl, data_fall_unused;

    ps2_sync_edge u_sync_clk (
        .clk     (clk),
        .reset   (reset),
        .line_in (ps2_clk),
        .level   (clk_level_unused),
        .fall    (clk_fall)
    );

    ps2_sync_edge u_sync_data (
        .clk     (clk),
        .reset   (reset),
        .line_in (ps2_data),
        .level   (data_lvl),
        .fall    (data_fall_unused)
    );

    ps2_state_e  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic [7:0]  keys_q, keys_d;
    logic [7:0]  scan_code_q, scan_code_d;
    logic        scan_valid_q, scan_valid_d;
    logic        frame_err_q, frame_err_d;
    key_map_t    map;

`ifdef PS2_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        keys_d       = keys_q;
        scan_code_d  = scan_code_q;
        scan_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        map          = lookup_key(shift_q, ext_q);

        if (clk_fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!data_lvl) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_lvl, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = data_lvl;
                    state_d  = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    if (data_lvl && (^{shift_q, parity_q})) begin
                        scan_valid_d = 1'b1;
                        scan_code_d  = shift_q;
                        if (shift_q == SC_EXT) begin
                            ext_d = 1'b1;
                        end else if (shift_q == SC_BRK) begin
                            brk_d = 1'b1;
                        end else begin
                            if (map.hit) begin
                                keys_d[map.idx] = ~brk_q;
                            end
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end
                end
            endcase
        end

`ifdef PS2_WATCHDOG_EN
        wd_d = '0;
        if (state_q != ST_IDLE && !clk_fall) begin
            if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                state_d     = ST_IDLE;
                frame_err_d = 1'b1;
                ext_d       = 1'b0;
                brk_d       = 1'b0;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            keys_q       <= 8'h00;
            scan_code_q  <= 8'h00;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef PS2_WATCHDOG_EN
            wd_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            keys_q       <= keys_d;
            scan_code_q  <= scan_code_d;
            scan_valid_q <= scan_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef PS2_WATCHDOG_EN
            wd_q         <= wd_d;
`endif
        end
    end

    assign p1_up      = keys_q[KEY_P1_UP];
    assign p1_down    = keys_q[KEY_P1_DOWN];
    assign p1_left    = keys_q[KEY_P1_LEFT];
    assign p1_right   = keys_q[KEY_P1_RIGHT];
    assign p2_up      = keys_q[KEY_P2_UP];
    assign p2_down    = keys_q[KEY_P2_DOWN];
    assign p2_left    = keys_q[KEY_P2_LEFT];
    assign p2_right   = keys_q[KEY_P2_RIGHT];
    assign scan_valid = scan_valid_q;
    assign scan_code  = scan_code_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: stimulus pushes expected byte/error events, a monitor pops them on each pulse.
module tb_ps2_key_decoder;

    localparam int TB_TIMEOUT = 2000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       p1_up, p1_down, p1_left, p1_right;
    logic       p2_up, p2_down, p2_left, p2_right;
    logic       scan_valid, frame_err;
    logic [7:0] scan_code;

    always #5 clk = ~clk;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .p1_up      (p1_up),
        .p1_down    (p1_down),
        .p1_left    (p1_left),
        .p1_right   (p1_right),
        .p2_up      (p2_up),
        .p2_down    (p2_down),
        .p2_left    (p2_left),
        .p2_right   (p2_right),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .frame_err  (frame_err)
    );

    // Key vector order: {p2_right,p2_left,p2_down,p2_up,p1_right,p1_left,p1_down,p1_up}
    wire [7:0] keys_out = {p2_right, p2_left, p2_down, p2_up, p1_right, p1_left, p1_down, p1_up};

    typedef struct {
        logic       is_err;
        logic [7:0] code;
        logic [7:0] keys;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_byte(input logic [7:0] code, input logic [7:0] keys);
        exp_t e;
        e.is_err = 1'b0;
        e.code   = code;
        e.keys   = keys;
        exp_q.push_back(e);
    endtask

    task automatic expect_err(input logic [7:0] code, input logic [7:0] keys);
        exp_t e;
        e.is_err = 1'b1;
        e.code   = code;
        e.keys   = keys;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (scan_valid || frame_err) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b code=%h keys=%h expected none",
                         scan_valid, frame_err, scan_code, keys_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", {6'd0, scan_valid, frame_err}, e.is_err ? 8'h01 : 8'h02);
                check("scan_code", scan_code, e.code);
                check("keys", keys_out, e.keys);
            end
        end
    end

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (5) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(stop_bit);
        ps2_data = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic good(input logic [7:0] b, input logic [7:0] keys_after);
        expect_byte(b, keys_after);
        send_frame(b, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] partial;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_keys", keys_out, 8'h00);
        check("reset_code", scan_code, 8'h00);
        check("reset_pulses", {6'd0, scan_valid, frame_err}, 8'h00);
        reset = 1'b0;
        repeat (5) @(posedge clk);

        // W make then break
        good(8'h1D, 8'h01);
        good(8'hF0, 8'h01);
        good(8'h1D, 8'h00);

        // Up arrow make/break, then bare keypad 8
        good(8'hE0, 8'h00);
        good(8'h75, 8'h10);
        good(8'hE0, 8'h10);
        good(8'hF0, 8'h10);
        good(8'h75, 8'h00);
        good(8'h75, 8'h00);

        // Bad parity D, then rejected frame clears a pending E0
        expect_err(8'h75, 8'h00);
        send_frame(8'h23, 1'b1, 1'b1);
        good(8'hE0, 8'h00);
        expect_err(8'hE0, 8'h00);
        send_frame(8'h11, 1'b1, 1'b1);
        good(8'h75, 8'h00);

        // W and S together, release S only, repeat W, bad stop bit
        good(8'h1D, 8'h01);
        good(8'h1B, 8'h03);
        good(8'hF0, 8'h03);
        good(8'h1B, 8'h01);
        good(8'h1D, 8'h01);
        expect_err(8'h1D, 8'h01);
        send_frame(8'h1C, 1'b0, 1'b0);

        // Reset after the 4th data bit discards the partial frame silently
        partial = 8'h1C;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(partial[i]);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midreset_keys", keys_out, 8'h00);
        check("midreset_code", scan_code, 8'h00);
        reset = 1'b0;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        good(8'h1C, 8'h04);

        // Remaining mappings, unmapped code, keypad break clears brk
        good(8'h23, 8'h0C);
        good(8'hE0, 8'h0C);
        good(8'h72, 8'h2C);
        good(8'hE0, 8'h2C);
        good(8'h6B, 8'h6C);
        good(8'hE0, 8'h6C);
        good(8'h74, 8'hEC);
        good(8'h1A, 8'hEC);
        good(8'hF0, 8'hEC);
        good(8'h75, 8'hEC);
        good(8'h1D, 8'hED);

`ifdef PS2_WATCHDOG_EN
        expect_err(8'h1D, 8'hED);
        partial = 8'h1B;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(partial[i]);
        ps2_data = 1'b1;
        repeat (TB_TIMEOUT + 50) @(posedge clk);
        good(8'h1B, 8'hEF);
`endif

        repeat (100) @(posedge clk);
        check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, SHALL set the watchdog limit in clk cycles (1 ms at 100 MHz).
REQ-002 Port clk  input  1  SHALL be the 100 MHz system clock; the block uses one clock.
REQ-003 Port reset  input  1  SHALL be the reset; it is synchronous and active-high.
REQ-004 Port ps2_clk  input  1  SHALL be the raw, asynchronous PS/2 clock; the top level ties off the inout.
REQ-005 Port ps2_data  input  1  SHALL be the raw, asynchronous PS/2 data line.
REQ-006 Ports p1_up, p1_down, p1_left, p1_right  output  1 each  SHALL be high while W, S, A, D respectively are held.
REQ-007 Ports p2_up, p2_down, p2_left, p2_right  output  1 each  SHALL be high while the Up, Down, Left, Right arrow keys respectively are held.
REQ-008 Port scan_valid  output  1  SHALL be a one-cycle pulse for each correctly received byte.
REQ-009 Port scan_code  output  8  SHALL hold the last correctly received byte.
REQ-010 Port frame_err  output  1  SHALL be a one-cycle pulse for each rejected frame.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be a synchronized 1 followed by a synchronized 0.
REQ-012 Receive FSM states SHALL be IDLE, DATA, PARITY and STOP; ps2_data SHALL be sampled only in the cycle a falling edge is detected.
REQ-013 IDLE SHALL move to DATA on a falling edge with data=0; data=1 at that edge SHALL be ignored with no error.
REQ-014 DATA SHALL shift in 8 bits LSB-first via a 3-bit counter, then go to PARITY.
REQ-015 PARITY SHALL store the bit and go to STOP; the frame is valid when the 9 bits have odd parity.
REQ-016 STOP SHALL return to IDLE; a stop bit of 1 with good parity is an accepted byte, anything else a rejected frame.
REQ-017 If the stop edge is detected in cycle N, scan_valid or frame_err SHALL be high in cycle N+1 only; scan_code and the key outputs SHALL update in cycle N+1.
REQ-018 Byte 0xE0 SHALL set the ext flag and byte 0xF0 the brk flag; neither changes the key outputs.
REQ-019 Any other accepted byte SHALL, if mapped, set its key output (brk=0) or clear it (brk=1), then clear ext and brk.
REQ-020 Mapping: non-ext 1D/1B/1C/23 SHALL drive p1_up/down/left/right; ext 75/72/6B/74 SHALL drive p2_up/down/left/right.
REQ-021 Codes 75/72/6B/74 without ext (keypad) and all unmapped codes SHALL leave the keys unchanged and clear the flags.
REQ-022 A rejected frame SHALL clear ext and brk and leave the key outputs unchanged.
REQ-023 Opposing keys held together (e.g. up and down) SHALL both read 1; resolving them is the consumer's job.
REQ-024 A repeated make code for a held key SHALL be idempotent.

Reset
REQ-025 While reset is high at a clk edge, the FSM SHALL enter IDLE and clear the bit counter, shift register, ext, brk and the synchronizers (to 1); all outputs SHALL be 0, scan_code 8'h00.
REQ-026 Reset mid-frame SHALL discard the partial frame without a frame_err pulse.

Configuration
REQ-027 With PS2_WATCHDOG_EN defined, a non-IDLE FSM SHALL return to IDLE after TIMEOUT_CYCLES clk cycles with no falling edge, pulse frame_err once and clear ext and brk; the counter resets on every falling edge.
REQ-028 Without PS2_WATCHDOG_EN, no timeout counter SHALL exist and a partial frame SHALL wait indefinitely.

Structure
REQ-029 Package ps2_pkg SHALL hold the FSM state enum, the scancode constants (E0, F0, the 8 key codes) and a key-index enum.
REQ-030 Sub-module ps2_sync_edge SHALL hold the synchronizer and falling-edge detector and be instantiated once per line (clock edge out, data level out).

Verification
REQ-031 Frame 0x1D, then F0 1D -> p1_up goes 1 one cycle after the first stop edge and 0 after the second; scan_valid pulses 3 times.
REQ-032 E0 75, then E0 F0 75 -> p2_up goes 1, then 0; bare 75 -> no key change, scan_valid pulses.
REQ-033 Frame 0x23 with even parity -> frame_err pulses once, scan_valid stays 0, p1_right stays 0; the next E0 flag is cleared.
REQ-034 W and S made together -> p1_up=p1_down=1; F0 1B -> only p1_down clears.
REQ-035 Reset asserted after the 4th data bit -> all outputs 0, no frame_err; the next full 0x1C frame sets p1_left.
REQ-036 With PS2_WATCHDOG_EN: stop after 5 bits and idle 100000 cycles -> one frame_err pulse, FSM IDLE; the next good frame decodes correctly.
